// File: rtl/alu_result_uart_tx_if.sv
// rtl/alu_result_uart_tx_if.sv - trigger/result request and tx/busy/done status bundle
interface alu_result_uart_tx_if;
  logic        trigger;
  logic [15:0] result;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    output trigger,
    output result,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  trigger,
    input  result,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/alu_result_uart_tx.sv
// rtl/alu_result_uart_tx.sv - sends a latched 16-bit ALU result as two back-to-back 8N1 UART frames
module alu_result_uart_tx #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter bit MSB_FIRST     = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  alu_result_uart_tx_if.slave link
);

  localparam int BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          byte_idx;
  logic [15:0]   hold;
  logic [7:0]    shift;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;

  logic          bit_end;
  logic [7:0]    first_byte;
  logic [7:0]    second_byte;

  assign bit_end     = (baud_cnt == BIT_LAST);
  // First byte comes straight from the input so the shifter is ready the cycle after trigger.
  assign first_byte  = MSB_FIRST ? link.result[15:8] : link.result[7:0];
  assign second_byte = MSB_FIRST ? hold[7:0] : hold[15:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
      hold     <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (link.trigger) begin
            hold     <= link.result;
            shift    <= first_byte;
            byte_idx <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!byte_idx) begin
              // Second frame follows with no idle gap.
              byte_idx <= 1'b1;
              shift    <= second_byte;
              tx_q     <= 1'b0;
              state    <= START;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign link.tx   = tx_q;
  assign link.busy = busy_q;
  assign link.done = done_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// tb/tb_alu_result_uart_tx.sv - scoreboard bench for alu_result_uart_tx
module tb_alu_result_uart_tx;

  logic        clk = 1'b0;
  logic        rst_d  [3];
  logic        trig_d [3];
  logic [15:0] res_d  [3];
  logic        tx_s   [3];
  logic        busy_s [3];
  logic        done_s [3];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_q [$];
  logic       wv   [$];

  always #5 clk = ~clk;

  alu_result_uart_tx_if if_lsb ();
  alu_result_uart_tx_if if_msb ();
  alu_result_uart_tx_if if_def ();

  assign if_lsb.trigger = trig_d[0];
  assign if_lsb.result  = res_d[0];
  assign if_msb.trigger = trig_d[1];
  assign if_msb.result  = res_d[1];
  assign if_def.trigger = trig_d[2];
  assign if_def.result  = res_d[2];
  assign tx_s[0] = if_lsb.tx;  assign busy_s[0] = if_lsb.busy;  assign done_s[0] = if_lsb.done;
  assign tx_s[1] = if_msb.tx;  assign busy_s[1] = if_msb.busy;  assign done_s[1] = if_msb.done;
  assign tx_s[2] = if_def.tx;  assign busy_s[2] = if_def.busy;  assign done_s[2] = if_def.done;

  alu_result_uart_tx #(.CLK_FREQUENCY(16), .BAUD_RATE(1), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(rst_d[0]), .link(if_lsb)
  );
  alu_result_uart_tx #(.CLK_FREQUENCY(16), .BAUD_RATE(1), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(rst_d[1]), .link(if_msb)
  );
  alu_result_uart_tx u_def (
    .clk(clk), .reset(rst_d[2]), .link(if_def)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference line level for sample i after the accepting edge.
  function automatic logic exp_tx(input int i, input int bitc, input bit msb, input logic [15:0] v);
    logic [7:0] by;
    int f, b;
    if (i >= 20 * bitc) return 1'b1;
    f  = i / (10 * bitc);
    b  = (i / bitc) % 10;
    by = ((f == 0) ^ msb) ? v[7:0] : v[15:8];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  task automatic push_bytes(input bit msb, input logic [15:0] v);
    sb_q.push_back(msb ? v[15:8] : v[7:0]);
    sb_q.push_back(msb ? v[7:0] : v[15:8]);
  endtask

  task automatic xfer(input int idx, input int bitc, input bit msb, input logic [15:0] val,
                      input bit fire, input bit chain, input logic [15:0] nval, input bit inject);
    int busy_cnt, done_cnt, done_idx, errs, pos, s;
    logic [7:0] d, e;
    busy_cnt = 0; done_cnt = 0; done_idx = -1; errs = 0;
    wv.delete();
    if (fire) begin
      @(negedge clk);
      res_d[idx]  = val;
      trig_d[idx] = 1'b1;
      push_bytes(msb, val);
    end
    for (int i = 0; i <= 20 * bitc; i++) begin
      @(negedge clk);
      trig_d[idx] = 1'b0;
      wv.push_back(tx_s[idx]);
      if (tx_s[idx] !== exp_tx(i, bitc, msb, val)) errs++;
      if (i < 20 * bitc && busy_s[idx] === 1'b1) busy_cnt++;
      if (done_s[idx] === 1'b1) begin
        done_cnt++;
        done_idx = i;
      end
      if (i == 20 * bitc) check("busy_end", {31'd0, busy_s[idx]}, 32'd0);
      if (inject && i == 3) res_d[idx] = 16'hFFFF;
      if (inject && (i == 5 || i == 100)) trig_d[idx] = 1'b1;
      if (chain && i == 20 * bitc) begin
        res_d[idx]  = nval;
        trig_d[idx] = 1'b1;
        push_bytes(msb, nval);
      end
    end
    check("wave_err", errs, 0);
    check("busy_len", busy_cnt, 20 * bitc);
    check("done_cnt", done_cnt, 1);
    check("done_idx", done_idx, 20 * bitc);
    if (!chain) begin
      @(negedge clk);
      check("done_width", {31'd0, done_s[idx]}, 32'd0);
      check("tx_idle", {31'd0, tx_s[idx]}, 32'd1);
    end
    pos = 0;
    for (int f = 0; f < 2; f++) begin
      s = pos;
      while (s < wv.size() && wv[s] !== 1'b0) s++;
      check("frame_start", s, f * 10 * bitc);
      if (s + 10 * bitc > wv.size()) begin
        check("frame_found", 0, 1);
        break;
      end
      for (int k = 0; k < 8; k++) d[k] = wv[s + (k + 1) * bitc + bitc / 2];
      check("stop_bit", {31'd0, wv[s + 9 * bitc + bitc / 2]}, 32'd1);
      if (sb_q.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("rx_byte", {24'd0, d}, {24'd0, e});
      end
      pos = s + 10 * bitc;
    end
  endtask

  initial begin
    int low_run, zeros, dones;
    for (int i = 0; i < 3; i++) begin
      rst_d[i] = 1'b1; trig_d[i] = 1'b0; res_d[i] = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_tx", {31'd0, tx_s[i]}, 32'd1);
      check("rst_busy", {31'd0, busy_s[i]}, 32'd0);
      check("rst_done", {31'd0, done_s[i]}, 32'd0);
    end
    for (int i = 0; i < 3; i++) rst_d[i] = 1'b0;
    repeat (2) @(negedge clk);

    xfer(0, 16, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0);
    xfer(1, 16, 1'b1, 16'hA55A, 1'b1, 1'b0, 16'h0, 1'b0);
    xfer(0, 16, 1'b0, 16'h3C81, 1'b1, 1'b0, 16'h0, 1'b1);
    xfer(1, 16, 1'b1, 16'h0F71, 1'b1, 1'b1, 16'hC3E6, 1'b0);
    xfer(1, 16, 1'b1, 16'hC3E6, 1'b0, 1'b0, 16'h0, 1'b0);

    @(negedge clk);
    res_d[0] = 16'h0F0F; trig_d[0] = 1'b1;
    @(negedge clk);
    trig_d[0] = 1'b0;
    repeat (2 * 16 + 3) @(negedge clk);
    rst_d[0] = 1'b1;
    @(negedge clk);
    check("abort_tx", {31'd0, tx_s[0]}, 32'd1);
    check("abort_busy", {31'd0, busy_s[0]}, 32'd0);
    rst_d[0] = 1'b0;
    zeros = 0; dones = 0;
    for (int i = 0; i < 25 * 16; i++) begin
      @(negedge clk);
      if (tx_s[0] !== 1'b1) zeros++;
      if (done_s[0] !== 1'b0) dones++;
    end
    check("abort_done", dones, 0);
    check("abort_line", zeros, 0);
    xfer(0, 16, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0);

    xfer(2, 868, 1'b0, 16'h00FF, 1'b1, 1'b0, 16'h0, 1'b0);
    low_run = 0;
    while (low_run < wv.size() && wv[low_run] === 1'b0) low_run++;
    check("bit_period", low_run, 868);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
